serial_adder: RTL and testbench
===============================

# serial_adder

Bit-serial WIDTH-bit adder built around the existing single-bit `full_adder` cell, reusing one cell over WIDTH clock cycles instead of instantiating WIDTH cells. It accepts an operand pair through a valid/ready handshake and shifts the operands through the cell LSB first, holding the carry in a flip-flop. It returns the sum and carry-out through a second valid/ready handshake. It is the sequential consumer of the full-adder cell, used where area matters more than latency.

## Interface
- `WIDTH`, default 8: operand and sum width in bits. Must be at least 2.
- `clk`  in  1  rising-edge clock
- `rst_n`  in  1  asynchronous active-low reset
- `start_valid`  in  1  operand pair is present
- `start_ready`  out  1  block can accept operands (asserted only in IDLE)
- `a`  in  WIDTH  operand A, sampled on the accepting edge
- `b`  in  WIDTH  operand B, sampled on the accepting edge
- `c_in`  in  1  carry-in, or borrow-in in subtract mode
- `sub`  in  1  subtract select; this port exists only with `SERIAL_ADDER_SUB_EN`
- `res_valid`  out  1  result is available
- `res_ready`  in  1  consumer takes the result
- `sum`  out  WIDTH  result word
- `c_out`  out  1  final carry

## Operation
- The FSM has three states, and reset enters IDLE.
- **IDLE**
  - `start_ready` = 1.
  - On `start_valid` & `start_ready`, load `a` and `b` into shift registers, load the carry flop from `c_in`, clear the bit counter, and go to RUN.
- **RUN**
  - Each cycle, feed `a_sr[0]`, `b_sr[0]` and the carry flop into `full_adder`.
  - Shift the cell's sum bit into `sum_sr` from the MSB side: `sum_sr <= {s, sum_sr[WIDTH-1:1]}`.
  - Capture the cell's carry into the carry flop, shift `a_sr` and `b_sr` right, and increment the counter.
  - After the bit at counter value WIDTH-1, go to DONE.
- **DONE**
  - `res_valid` = 1.
  - `sum` and `c_out` are held stable.
  - On `res_ready`, go to IDLE.
  - `start_valid` is ignored here.
- Arithmetic in add mode: {`c_out`, `sum`} = `a` + `b` + `c_in`, computed modulo 2^(WIDTH+1).
- Outside DONE, `sum` and `c_out` are don't-care.
- The counter is $clog2(WIDTH) bits wide. It never wraps, because exit happens at WIDTH-1.
- Inputs `a`, `b`, `c_in` and `sub` may change freely after the accepting edge.
- Reset, including reset asserted mid-RUN or mid-DONE:
  - Immediately abort any operation and return to IDLE.
  - The partial result is discarded and never presented.
- Reset values:
  - `start_ready` = 0 while `rst_n` is low, then 1 once in IDLE.
  - `res_valid` = 0.
  - `sum` = 0.
  - `c_out` = 0.
  - All shift registers, the carry flop and the counter = 0.

## Timing
- Accepting edge E0 enters RUN. RUN lasts WIDTH cycles. `res_valid` rises on edge E(WIDTH).
- Latency from accept to `res_valid` is WIDTH cycles.
- A result transfers on the edge where `res_valid` & `res_ready` are both high. `start_ready` rises on that same edge.
- Minimum initiation interval is WIDTH+2 cycles, because the IDLE cycle is mandatory.
- `res_valid` is never withdrawn before transfer.
- `start_ready` is 0 throughout RUN and DONE.
- All outputs are registered or decoded from state only. There are no combinational paths from inputs to outputs.

## Configuration
- **`SERIAL_ADDER_SUB_EN` defined:**
  - The `sub` port exists and is latched on the accepting edge.
  - When `sub` = 1, feed the inverted `b_sr[0]` into the cell and load the carry flop with ~`c_in`.
  - This gives `sum` = `a` - `b` - `c_in`, modulo 2^WIDTH.
  - `c_out` = 1 means no borrow occurred.
  - When `sub` = 0, behaviour matches the undefined build.
- **Undefined:**
  - No `sub` port and no inversion logic.
  - Add only.

## Structure
- Shared package `serial_adder_pkg` holds the state typedef (IDLE, RUN, DONE) and the state encoding constants.
- The one sub-module is the existing `full_adder` (ports `a`, `b`, `c_in`, `sum`, `c_out`), instantiated exactly once.
- The shift registers, counter and FSM stay in `serial_adder`.

## Test plan
- **Basic add:** WIDTH=8, accept `a`=0x5A, `b`=0x3C, `c_in`=0. Expect `sum`=0x96 and `c_out`=0, with `res_valid` rising exactly 8 cycles after the accepting edge.
- **Carry chain:** `a`=0xFF, `b`=0x01, `c_in`=1. Expect `sum`=0x01 and `c_out`=1.
- **Backpressure:**
  - Hold `res_ready`=0 for 5 cycles in DONE while pulsing `start_valid` with new operands.
  - Expect `res_valid`=1, `sum` and `c_out` stable, `start_ready`=0, and the new operands not accepted.
  - After `res_ready`, the next accept produces the correct result.
- **Reset mid-operation:**
  - Assert `rst_n`=0 during RUN at bit 3.
  - Expect `res_valid`=0, `sum`=0, `c_out`=0 and `start_ready`=0 immediately.
  - After release, `a`=0x01, `b`=0x02 gives `sum`=0x03, `c_out`=0.
- **Subtract (with `SERIAL_ADDER_SUB_EN`):**
  - `sub`=1, 0x10 - 0x01, `c_in`=0 -> `sum`=0x0F, `c_out`=1.
  - 0x00 - 0x01 -> `sum`=0xFF, `c_out`=0.
- **Back-to-back:** 4 operand pairs offered continuously with `res_ready`=1. Expect a transfer every 10 cycles (WIDTH+2) and all sums correct.

Source files
------------

// File: rtl/serial_adder_pkg.sv
// Shared definitions for the bit-serial adder: FSM state type and encodings.
package serial_adder_pkg;

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_RUN  = 2'd1;
    localparam logic [1:0] ST_DONE = 2'd2;

    typedef enum logic [1:0] {
        IDLE = ST_IDLE,
        RUN  = ST_RUN,
        DONE = ST_DONE
    } state_t;

endpackage

// File: rtl/full_adder.sv
// Single-bit full adder cell.
module full_adder (
    input  logic a,
    input  logic b,
    input  logic c_in,
    output logic sum,
    output logic c_out
);

    assign sum   = a ^ b ^ c_in;
    assign c_out = (a & b) | (c_in & (a ^ b));

endmodule

// File: rtl/serial_adder.sv
// Bit-serial WIDTH-bit adder reusing one full_adder cell over WIDTH cycles, LSB first.
// Define SERIAL_ADDER_SUB_EN to add the sub port and a - b - c_in subtract mode.
//
// state | meaning
// IDLE  | ready for an operand pair
// RUN   | one bit per cycle through the cell
// DONE  | result presented until res_ready
module serial_adder
    import serial_adder_pkg::*;
#(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start_valid,
    output logic             start_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             c_in,
`ifdef SERIAL_ADDER_SUB_EN
    input  logic             sub,
`endif
    output logic             res_valid,
    input  logic             res_ready,
    output logic [WIDTH-1:0] sum,
    output logic             c_out
);

    localparam int            CW       = $clog2(WIDTH);
    localparam logic [CW-1:0] LAST_BIT = CW'(WIDTH - 1);

    state_t           state;
    logic [WIDTH-1:0] a_sr;
    logic [WIDTH-1:0] b_sr;
    logic [WIDTH-1:0] sum_sr;
    logic             carry;
    logic [CW-1:0]    cnt;
    logic             b_bit;
    logic             fa_sum;
    logic             fa_cout;

`ifdef SERIAL_ADDER_SUB_EN
    logic sub_q;
    // Two's-complement subtract: invert b bit-by-bit, carry was preloaded with ~c_in.
    assign b_bit = b_sr[0] ^ sub_q;
`else
    assign b_bit = b_sr[0];
`endif

    full_adder u_fa (
        .a     (a_sr[0]),
        .b     (b_bit),
        .c_in  (carry),
        .sum   (fa_sum),
        .c_out (fa_cout)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state       <= IDLE;
            a_sr        <= '0;
            b_sr        <= '0;
            sum_sr      <= '0;
            carry       <= 1'b0;
            cnt         <= '0;
            start_ready <= 1'b0;
            res_valid   <= 1'b0;
`ifdef SERIAL_ADDER_SUB_EN
            sub_q       <= 1'b0;
`endif
        end else begin
            case (state)
                IDLE: begin
                    start_ready <= 1'b1;
                    if (start_valid && start_ready) begin
                        a_sr        <= a;
                        b_sr        <= b;
                        cnt         <= '0;
                        start_ready <= 1'b0;
                        state       <= RUN;
`ifdef SERIAL_ADDER_SUB_EN
                        sub_q       <= sub;
                        carry       <= c_in ^ sub;
`else
                        carry       <= c_in;
`endif
                    end
                end
                RUN: begin
                    sum_sr <= {fa_sum, sum_sr[WIDTH-1:1]};
                    carry  <= fa_cout;
                    a_sr   <= a_sr >> 1;
                    b_sr   <= b_sr >> 1;
                    if (cnt == LAST_BIT) begin
                        state     <= DONE;
                        res_valid <= 1'b1;
                    end else begin
                        cnt <= cnt + CW'(1);
                    end
                end
                DONE: begin
                    if (res_ready) begin
                        state       <= IDLE;
                        res_valid   <= 1'b0;
                        start_ready <= 1'b1;
                    end
                end
                default: begin
                    state       <= IDLE;
                    res_valid   <= 1'b0;
                    start_ready <= 1'b0;
                end
            endcase
        end
    end

    assign sum   = sum_sr;
    assign c_out = carry;

endmodule

// File: tb/tb_serial_adder.sv
// Bench for serial_adder: directed and random operand pairs against an arithmetic model.
module tb_serial_adder;

    localparam int W = 8;

    logic         clk         = 1'b0;
    logic         rst_n       = 1'b0;
    logic         start_valid = 1'b0;
    logic         c_in        = 1'b0;
    logic         res_ready   = 1'b0;
    logic [W-1:0] a           = '0;
    logic [W-1:0] b           = '0;
    logic         start_ready;
    logic         res_valid;
    logic [W-1:0] sum;
    logic         c_out;
`ifdef SERIAL_ADDER_SUB_EN
    logic         sub         = 1'b0;
`endif

    int errors = 0;
    int checks = 0;

    always #5 clk = ~clk;

    serial_adder #(.WIDTH(W)) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .start_valid (start_valid),
        .start_ready (start_ready),
        .a           (a),
        .b           (b),
        .c_in        (c_in),
`ifdef SERIAL_ADDER_SUB_EN
        .sub         (sub),
`endif
        .res_valid   (res_valid),
        .res_ready   (res_ready),
        .sum         (sum),
        .c_out       (c_out)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp)
        else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // {c_out, sum} from plain integer arithmetic; subtract reports c_out=1 when no borrow.
    function automatic logic [W:0] model(input logic [W-1:0] x, input logic [W-1:0] y,
                                         input logic ci, input logic sb);
        int t;
        if (sb) begin
            t = int'(x) - int'(y) - int'(ci);
            return {(t >= 0), W'((t + 2**W) % 2**W)};
        end
        t = int'(x) + int'(y) + int'(ci);
        return (W+1)'(t);
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic scramble_inputs();
        a    = W'($urandom);
        b    = W'($urandom);
        c_in = 1'($urandom);
`ifdef SERIAL_ADDER_SUB_EN
        sub  = 1'($urandom);
`endif
    endtask

    task automatic run_op(input string tag, input logic [W-1:0] x, input logic [W-1:0] y,
                          input logic ci, input logic sb, input int hold);
        logic [W:0] exp;
        int k;
        exp = model(x, y, ci, sb);
        k = 0;
        while (!start_ready && k < 50) begin
            tick();
            k++;
        end
        check({tag, "_start_ready"}, start_ready, 1);
        a = x;
        b = y;
        c_in = ci;
`ifdef SERIAL_ADDER_SUB_EN
        sub = sb;
`endif
        start_valid = 1'b1;
        tick();
        start_valid = 1'b0;
        scramble_inputs();
        check({tag, "_accepted"}, start_ready, 0);
        k = 0;
        while (!res_valid && k < 50) begin
            tick();
            k++;
        end
        check({tag, "_latency"}, k, W);
        check({tag, "_sum"}, sum, exp[W-1:0]);
        check({tag, "_c_out"}, c_out, exp[W]);
        for (int i = 0; i < hold; i++) begin
            start_valid = 1'b1;
            scramble_inputs();
            tick();
            check({tag, "_hold_valid"}, res_valid, 1);
            check({tag, "_hold_sum"}, sum, exp[W-1:0]);
            check({tag, "_hold_c_out"}, c_out, exp[W]);
            check({tag, "_hold_ready"}, start_ready, 0);
        end
        start_valid = 1'b0;
        res_ready = 1'b1;
        tick();
        res_ready = 1'b0;
        check({tag, "_valid_drop"}, res_valid, 0);
        check({tag, "_ready_rise"}, start_ready, 1);
    endtask

    initial begin
        logic [W:0] q[$];
        logic [W:0] e;
        logic       sb;
        logic       acc;
        logic       xf;
        int         cyc;
        int         last_x;
        int         done_n;
        int         offered;

        // Reset state
        #1;
        check("rst_start_ready", start_ready, 0);
        check("rst_res_valid", res_valid, 0);
        check("rst_sum", sum, 0);
        check("rst_c_out", c_out, 0);
        #20;
        rst_n = 1'b1;
        #1;
        check("rst_release_ready", start_ready, 0);
        tick();
        check("idle_ready", start_ready, 1);

        run_op("basic", 8'h5A, 8'h3C, 1'b0, 1'b0, 0);
        run_op("carry", 8'hFF, 8'h01, 1'b1, 1'b0, 0);
        run_op("zero", 8'h00, 8'h00, 1'b0, 1'b0, 0);
        run_op("max", 8'hFF, 8'hFF, 1'b1, 1'b0, 0);

        run_op("bp", 8'h77, 8'h11, 1'b1, 1'b0, 5);
        run_op("after_bp", 8'h80, 8'h80, 1'b0, 1'b0, 0);

        // Reset while bit 3 is in the cell
        a = 8'hF0;
        b = 8'h0F;
        c_in = 1'b1;
        start_valid = 1'b1;
        tick();
        start_valid = 1'b0;
        tick();
        tick();
        tick();
        rst_n = 1'b0;
        #1;
        check("midrst_res_valid", res_valid, 0);
        check("midrst_sum", sum, 0);
        check("midrst_c_out", c_out, 0);
        check("midrst_start_ready", start_ready, 0);
        #10;
        rst_n = 1'b1;
        tick();
        check("midrst_idle_ready", start_ready, 1);
        check("midrst_no_result", res_valid, 0);
        run_op("post_rst", 8'h01, 8'h02, 1'b0, 1'b0, 0);

`ifdef SERIAL_ADDER_SUB_EN
        run_op("sub_basic", 8'h10, 8'h01, 1'b0, 1'b1, 0);
        run_op("sub_borrow", 8'h00, 8'h01, 1'b0, 1'b1, 0);
        run_op("sub_cin", 8'h05, 8'h05, 1'b1, 1'b1, 0);
`endif

        for (int i = 0; i < 16; i++) begin
            sb = 1'b0;
`ifdef SERIAL_ADDER_SUB_EN
            sb = 1'($urandom);
`endif
            run_op("rand", W'($urandom), W'($urandom), 1'($urandom), sb, i % 3);
        end

        // Back-to-back: continuous offer, consumer always ready
        offered = 0;
        done_n = 0;
        cyc = 0;
        last_x = 0;
        res_ready = 1'b1;
        scramble_inputs();
        sb = 1'b0;
`ifdef SERIAL_ADDER_SUB_EN
        sb = sub;
`endif
        q.push_back(model(a, b, c_in, sb));
        start_valid = 1'b1;
        while (done_n < 4 && cyc < 200) begin
            acc = start_valid && start_ready;
            xf = res_valid && res_ready;
            if (xf) begin
                e = q.pop_front();
                check("b2b_sum", sum, e[W-1:0]);
                check("b2b_c_out", c_out, e[W]);
                if (done_n > 0) check("b2b_interval", cyc - last_x, W + 2);
                last_x = cyc;
                done_n++;
            end
            tick();
            cyc++;
            if (acc) begin
                offered++;
                if (offered < 4) begin
                    scramble_inputs();
                    sb = 1'b0;
`ifdef SERIAL_ADDER_SUB_EN
                    sb = sub;
`endif
                    q.push_back(model(a, b, c_in, sb));
                end else begin
                    start_valid = 1'b0;
                end
            end
        end
        check("b2b_count", done_n, 4);
        res_ready = 1'b0;
        start_valid = 1'b0;

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
